// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: each channel is OFF/ON/BLINK/PWM, paced by a shared
// prescaler tick and configured one channel at a time through a valid/ready port.
module led_pattern_gen #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned PRESC_DIV = 100000,
   parameter int unsigned PER_W     = 10,
   // one spare code above the channel range so that out-of-range targets can be flagged
   localparam int unsigned CH_W     = $clog2(NUM_CH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [1:0]        cfg_mode,
   input  logic [PER_W-1:0]  cfg_period,
   input  logic [PER_W-1:0]  cfg_duty,
   output logic              cfg_err,
   output logic              tick,
   output logic [NUM_CH-1:0] led
);

   localparam int unsigned      CNT_W    = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESC_DIV - 1);

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_ON    = 2'b01;
   localparam logic [1:0] MODE_BLINK = 2'b10;
   localparam logic [1:0] MODE_PWM   = 2'b11;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_APPLY = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic              do_accept, do_apply;
   logic [CH_W-1:0]   hold_ch;
   logic [1:0]        hold_mode;
   logic [PER_W-1:0]  hold_period, hold_duty;
   logic [CNT_W-1:0]  presc_q;
   logic [1:0]        mode_q   [NUM_CH];
   logic [PER_W-1:0]  period_q [NUM_CH];
   logic [PER_W-1:0]  duty_q   [NUM_CH];
   logic [PER_W-1:0]  phase_q  [NUM_CH];
   logic [NUM_CH-1:0] blink_q;
   logic [NUM_CH-1:0] led_c;

   // Prescaler: tick is registered, so it is high the cycle after the count hits its last value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         tick    <= 1'b0;
      end else if (enable) begin
         presc_q <= (presc_q == CNT_LAST) ? '0 : presc_q + CNT_W'(1);
         tick    <= (presc_q == CNT_LAST);
      end else begin
         tick    <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Config FSM: accept in IDLE, commit to the channel registers in APPLY
   always_comb begin
      state_d   = state_q;
      do_accept = 1'b0;
      do_apply  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cfg_valid && cfg_ready) begin
               do_accept = 1'b1;
               state_d   = S_APPLY;
            end
         end
         S_APPLY: begin
            do_apply = 1'b1;
            state_d  = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_ready   <= 1'b1;
         cfg_err     <= 1'b0;
         hold_ch     <= '0;
         hold_mode   <= MODE_OFF;
         hold_period <= '0;
         hold_duty   <= '0;
      end else begin
         cfg_ready <= (state_d == S_IDLE);
         cfg_err   <= do_apply && (hold_ch >= CH_W'(NUM_CH));
         if (do_accept) begin
            hold_ch     <= cfg_ch;
            hold_mode   <= cfg_mode;
            hold_period <= cfg_period;
            hold_duty   <= cfg_duty;
         end
      end
   end

   // Channel state: a config write takes priority over a same-cycle tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            mode_q[i]   <= MODE_OFF;
            period_q[i] <= '0;
            duty_q[i]   <= '0;
            phase_q[i]  <= '0;
         end
         blink_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (do_apply && (hold_ch == CH_W'(i))) begin
               mode_q[i]   <= hold_mode;
               period_q[i] <= hold_period;
               duty_q[i]   <= hold_duty;
               phase_q[i]  <= '0;
               blink_q[i]  <= 1'b0;
            end else if (enable && tick && (period_q[i] != '0)) begin
               if (phase_q[i] >= period_q[i] - PER_W'(1)) begin
                  phase_q[i] <= '0;
                  blink_q[i] <= ~blink_q[i];
               end else begin
                  phase_q[i] <= phase_q[i] + PER_W'(1);
               end
            end
         end
      end
   end

   always_comb begin
      led_c = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         case (mode_q[i])
            MODE_OFF:   led_c[i] = 1'b0;
            MODE_ON:    led_c[i] = 1'b1;
            MODE_BLINK: led_c[i] = (period_q[i] != '0) && blink_q[i];
            MODE_PWM:   led_c[i] = (period_q[i] != '0) && (phase_q[i] < duty_q[i]);
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) led <= '0;
      else        led <= enable ? led_c : '0;
   end

endmodule
